regfile_mp: RTL and testbench

//   Parametrised multi-port register file for the pipelined datapath; successor to the fixed
//   32x32, 2-read/1-write file. Adds configurable width, depth and port counts, synchronous clear,

---
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: prioritised multi-write, optional bypass and zero register.
// Read latency 0 (RD_REG=0) or 1 cycle (RD_REG=1); no backpressure, every port is serviced each cycle.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_REG   = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NW-1:0]       we,
    input  logic [NW*AW-1:0]    wa,
    input  logic [NW*WIDTH-1:0] wd,
    input  logic [NR*AW-1:0]    ra,
    output logic [NR*WIDTH-1:0] rd
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] rf [DEPTH];
    logic [AW-1:0]    wa_a [NW];
    logic [WIDTH-1:0] wd_a [NW];
    logic [AW-1:0]    ra_a [NR];
    logic [WIDTH-1:0] raw  [NR];
    logic [NW-1:0]    wv;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    for (genvar w = 0; w < NW; w++) begin : g_wunpack
        assign wa_a[w] = wa[w*AW +: AW];
        assign wd_a[w] = wd[w*WIDTH +: WIDTH];
    end

    for (genvar r = 0; r < NR; r++) begin : g_runpack
        assign ra_a[r] = ra[r*AW +: AW];
    end

    // Only effective writes may touch storage or the bypass path.
    always_comb begin
        wv = '0;
        for (int w = 0; w < NW; w++) begin
            wv[w] = reset && we[w] && addr_ok(wa_a[w]);
        end
    end

    // Ascending port order: the last assignment, i.e. highest-index port, wins on a conflict.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wv[w]) begin
                    rf[wa_a[w]] <= wd_a[w];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            raw[r] = '0;
            if (addr_ok(ra_a[r])) begin
                raw[r] = rf[ra_a[r]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NW; w++) begin
                        if (wv[w] && (wa_a[w] == ra_a[r])) begin
                            raw[r] = wd_a[w];
                        end
                    end
                end
            end
        end
    end

    if (RD_REG != 0) begin : g_rreg
        logic [WIDTH-1:0] rq [NR];

        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int r = 0; r < NR; r++) begin
                    rq[r] <= '0;
                end
            end else begin
                for (int r = 0; r < NR; r++) begin
                    rq[r] <= raw[r];
                end
            end
        end

        for (genvar r = 0; r < NR; r++) begin : g_out
            assign rd[r*WIDTH +: WIDTH] = reset ? rq[r] : '0;
        end
    end else begin : g_comb
        for (genvar r = 0; r < NR; r++) begin : g_out
            assign rd[r*WIDTH +: WIDTH] = reset ? raw[r] : '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp across three parameter sets sharing one clock and reset.
module tb_regfile_mp;

    logic clk;
    logic reset;

    // u0: defaults (32x32, NR=2, NW=1, zero reg, bypass, combinational read)
    logic [0:0]  we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [9:0]  ra0;
    logic [63:0] rd0;

    // u1: DEPTH=24, NW=3, ordinary entry 0, bypass, combinational read
    logic [2:0]  we1;
    logic [14:0] wa1;
    logic [95:0] wd1;
    logic [9:0]  ra1;
    logic [63:0] rd1;

    // u2: NR=1, zero reg, no bypass, registered read
    logic [0:0]  we2;
    logic [4:0]  wa2;
    logic [31:0] wd2;
    logic [4:0]  ra2;
    logic [31:0] rd2;

    int n_vec = 0;
    int n_err = 0;

    regfile_mp u0 (
        .clk(clk), .reset(reset), .we(we0), .wa(wa0), .wd(wd0), .ra(ra0), .rd(rd0)
    );

    regfile_mp #(.DEPTH(24), .NW(3), .ZERO_REG(0), .BYPASS(1), .RD_REG(0)) u1 (
        .clk(clk), .reset(reset), .we(we1), .wa(wa1), .wd(wd1), .ra(ra1), .rd(rd1)
    );

    regfile_mp #(.NR(1), .ZERO_REG(1), .BYPASS(0), .RD_REG(1)) u2 (
        .clk(clk), .reset(reset), .we(we2), .wa(wa2), .wd(wd2), .ra(ra2), .rd(rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        we0 = '0; wa0 = '0; wd0 = '0; ra0 = '0;
        we1 = '0; wa1 = '0; wd1 = '0; ra1 = '0;
        we2 = '0; wa2 = '0; wd2 = '0; ra2 = '0;
        tick;
        chk("rst_rd0", rd0, 64'h0);
        chk("rst_rd1", rd1, 64'h0);
        chk("rst_rd2", rd2, 64'h0);
        reset = 1'b1;
        #1;

        // T1: every entry reads 0 after reset, then a basic write/read
        for (int a = 0; a < 32; a++) begin
            ra0 = {5'(a), 5'(a)};
            #1;
            chk($sformatf("t1_clr_a%0d", a), rd0, 64'h0);
        end
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        tick;
        we0 = 1'b0; ra0 = {5'd0, 5'd5};
        #1;
        chk("t1_rd_a5", rd0[31:0], 64'hDEADBEEF);

        // T3 (bypass on u0)
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111;
        tick;
        wd0 = 32'h2222; ra0 = {5'd7, 5'd5};
        #1;
        chk("t3_byp_lane1", rd0[63:32], 64'h2222);
        chk("t3_lane0_indep", rd0[31:0], 64'hDEADBEEF);
        tick;
        we0 = 1'b0;
        #1;
        chk("t3_after", rd0[63:32], 64'h2222);

        // T2: zero register on u0 (writes dropped, no bypass)
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra0 = {5'd0, 5'd0};
        #1;
        chk("t2_zero_byp", rd0, 64'h0);
        tick;
        we0 = 1'b0;
        #1;
        chk("t2_zero_rd", rd0, 64'h0);

        // T2: entry 0 is ordinary on u1
        we1 = 3'b001; wa1 = {5'd0, 5'd0, 5'd0}; wd1 = {32'h0, 32'h0, 32'hFFFFFFFF};
        tick;
        we1 = '0; ra1 = {5'd0, 5'd0};
        #1;
        chk("t2_nozero_rd", rd1, 64'hFFFFFFFF_FFFFFFFF);

        // T4: three-way conflict, highest port wins both in storage and bypass
        we1 = 3'b111; wa1 = {5'd9, 5'd9, 5'd9}; wd1 = {32'hC, 32'hB, 32'hA}; ra1 = {5'd0, 5'd9};
        #1;
        chk("t4_byp", rd1[31:0], 64'hC);
        tick;
        we1 = '0;
        #1;
        chk("t4_rd", rd1[31:0], 64'hC);
        we1 = 3'b011; wa1 = {5'd10, 5'd10, 5'd10}; wd1 = {32'h3, 32'h2, 32'h1}; ra1 = {5'd10, 5'd9};
        #1;
        chk("t4_byp_p1", rd1[63:32], 64'h2);
        tick;
        we1 = 3'b101; wd1 = {32'h33, 32'h22, 32'h11};
        tick;
        we1 = '0;
        #1;
        chk("t4_rd_p2", rd1[63:32], 64'h33);

        // T6: non-power-of-two depth
        for (int i = 0; i < 24; i++) begin
            we1 = 3'b001; wa1 = {5'd0, 5'd0, 5'(i)}; wd1 = {64'h0, 32'h100 + 32'(i)};
            tick;
        end
        we1 = 3'b111; wa1 = {5'd30, 5'd24, 5'd30}; wd1 = {32'hBAD2, 32'hBAD1, 32'hBAD0};
        ra1 = {5'd24, 5'd30};
        #1;
        chk("t6_oor_byp", rd1, 64'h0);
        tick;
        we1 = '0;
        #1;
        chk("t6_oor_rd", rd1, 64'h0);
        for (int i = 0; i < 24; i++) begin
            ra1 = {5'(i), 5'(23 - i)};
            #1;
            chk($sformatf("t6_keep_%0d", i), rd1,
                {32'h100 + 32'(i), 32'h100 + 32'(23 - i)});
        end

        // T5: registered read, no bypass, reset mid-operation
        we2 = 1'b1; wa2 = 5'd3; wd2 = 32'h55;
        tick;
        we2 = 1'b0; ra2 = 5'd3;
        tick;
        chk("t5_rreg", rd2, 64'h55);
        we2 = 1'b1; wd2 = 32'h66;
        tick;
        chk("t5_nobyp_old", rd2, 64'h55);
        we2 = 1'b0;
        tick;
        chk("t5_nobyp_new", rd2, 64'h66);
        we2 = 1'b1; wa2 = 5'd0; wd2 = 32'hFFFFFFFF;
        tick;
        we2 = 1'b0; ra2 = 5'd0;
        tick;
        chk("t5_zero_rreg", rd2, 64'h0);

        ra2 = 5'd3;
        tick;
        chk("t5_pre_rst", rd2, 64'h66);
        reset = 1'b0; we2 = 1'b1; wa2 = 5'd3; wd2 = 32'h77;
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678; ra0 = {5'd7, 5'd5};
        #1;
        chk("t5_rst_forced", rd2, 64'h0);
        chk("t5_rst_forced_u0", rd0, 64'h0);
        tick;
        reset = 1'b1; we2 = 1'b0; we0 = 1'b0;
        #1;
        chk("t5_rq_cleared", rd2, 64'h0);
        chk("rst_u0_clr", rd0, 64'h0);
        ra1 = {5'd9, 5'd0};
        #1;
        chk("rst_u1_clr", rd1, 64'h0);
        tick;
        chk("t5_rf3_cleared", rd2, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
